// File: rtl/screen_view_ctrl.sv
// Display source/scroll sequencer in front of screen_driver (includes calc_pkg).
// Optional idle timeout enabled by defining SCREEN_VIEW_TIMEOUT_EN.
package calc_pkg;
  localparam int NumDigits = 8;
  typedef struct packed {
    logic [31:0] significand;
    logic [2:0]  exponent;
  } num_t;
endpackage

module screen_view_ctrl #(
  parameter int NumDigits     = calc_pkg::NumDigits,
  parameter int TimeoutCycles = 100_000_000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  calc_pkg::num_t   num_entry_i,
  input  logic             entry_valid_i,
  input  calc_pkg::num_t   num_result_i,
  input  logic             result_valid_i,
  input  logic             scroll_left_i,
  input  logic             scroll_right_i,
  output calc_pkg::num_t   num_o,
  output logic             override_shift_amount_o,
  output logic [2:0]       new_shift_amount_o,
  output logic             showing_result_o
);

  typedef enum logic {SRC_ENTRY, SRC_RESULT} src_t;

  src_t           src_q;
  calc_pkg::num_t result_q;
  logic           ovr_q;
  logic [2:0]     shift_q;

  logic [2:0] frac;
  logic [2:0] base;
  logic [2:0] stepped;
  logic       src_evt;
  logic       scroll_ok;
  logic       expire;

  assign num_o                   = (src_q == SRC_RESULT) ? result_q : num_entry_i;
  assign showing_result_o        = (src_q == SRC_RESULT);
  assign override_shift_amount_o = ovr_q;
  assign new_shift_amount_o      = shift_q;

  assign src_evt   = result_valid_i | entry_valid_i;
  assign frac      = 3'(NumDigits - 1) - num_o.exponent;
  assign scroll_ok = (scroll_left_i ^ scroll_right_i) && (frac != 3'd0);

  // The first scroll starts from the auto-aligned position (all fraction shown).
  always_comb begin
    base    = ovr_q ? shift_q : frac;
    stepped = base;
    if (scroll_left_i) begin
      stepped = (base == 3'd0) ? 3'd0 : base - 3'd1;
    end else if (base >= frac) begin
      stepped = frac;
    end else begin
      stepped = base + 3'd1;
    end
  end

`ifdef SCREEN_VIEW_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles);
  logic [CntW-1:0] cnt_q;

  assign expire = ovr_q && (cnt_q == CntW'(TimeoutCycles - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (src_evt || scroll_ok || !ovr_q || expire) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign expire = 1'b0;
`endif

  // Source events outrank scrolls; an accepted scroll outranks expiry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q    <= SRC_ENTRY;
      result_q <= '0;
      ovr_q    <= 1'b0;
      shift_q  <= 3'd0;
    end else if (src_evt) begin
      if (result_valid_i) begin
        src_q    <= SRC_RESULT;
        result_q <= num_result_i;
      end else begin
        src_q <= SRC_ENTRY;
      end
      ovr_q   <= 1'b0;
      shift_q <= 3'd0;
    end else if (scroll_ok) begin
      ovr_q   <= 1'b1;
      shift_q <= stepped;
    end else if (expire) begin
      ovr_q   <= 1'b0;
      shift_q <= 3'd0;
    end
  end

endmodule
